// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matrix-op sequencer.
//   - op_code_e : decode op codes
//   - wr_sel_e  : array write-target select encoding
//   - state_e   : sequencer states
//   - DIM_DEF, steps_for() : default array edge and systolic step count
//   - is_matrix_op() : true for the six codes that do something
package matmul_pkg;

  localparam int DIM_DEF = 4;

  // A full DIM x DIM product needs 3*DIM-2 wavefront steps through the array.
  function automatic int steps_for(input int dim);
    return 3 * dim - 2;
  endfunction

  typedef enum logic [2:0] {
    OP_NONE     = 3'b000,
    OP_WRITE_A  = 3'b001,
    OP_WRITE_B  = 3'b010,
    OP_WRITE_C  = 3'b011,
    OP_MATMUL   = 3'b100,
    OP_READ_C   = 3'b101,
    OP_SYS_STEP = 3'b110,
    OP_RSVD     = 3'b111
  } op_code_e;

  typedef enum logic [1:0] {
    WR_SEL_NONE = 2'b00,
    WR_SEL_A    = 2'b01,
    WR_SEL_B    = 2'b10,
    WR_SEL_C    = 2'b11
  } wr_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_READ = 2'b10
  } state_e;

  function automatic logic is_matrix_op(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

endpackage

// File: rtl/matmul_step_counter.sv
// matmul_step_counter: down-counter pacing a matmul run.
//   clk, rst  : clock, async active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded on load
//   dec       : decrement by one
//   zero      : count == 0
module matmul_step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: sequencer turning decoded matrix ops into systolic-array
// strobes (row writes, step pulses, full matmul runs, C row reads).
// Optional feature: define MATMUL_SEQ_PERF_EN to count RUN cycles on
// perf_cycles (saturating); otherwise perf_cycles is tied to zero.
//   clk, rst          : clock, async active-high reset
//   op_valid/op_code  : decoded op presented this cycle
//   op_idx/op_high_low: target row and readC half select
//   stall             : op not accepted (combinational)
//   arr_wr_en/_sel    : one-cycle row write strobe and target matrix
//   arr_row           : row for write/read
//   arr_step          : advance array one step
//   arr_rd_en/_hl     : row read strobe and half select
//   rd_valid          : readC data valid
//   busy              : sequencer not idle
//   result_ready      : C holds a completed matmul result
//   perf_cycles       : RUN-cycle counter
//
// state  | meaning
// IDLE   | accepting ops; single-cycle ops issue from here
// RUN    | matmul in progress, arr_step every cycle for STEPS cycles
// READ   | C row read issued, rd_valid follows next cycle
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int STEPS = steps_for(DIM)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   op_valid,
  input  logic [2:0]                             op_code,
  input  logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] op_idx,
  input  logic                                   op_high_low,
  output logic                                   stall,
  output logic                                   arr_wr_en,
  output logic [1:0]                             arr_wr_sel,
  output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] arr_row,
  output logic                                   arr_step,
  output logic                                   arr_rd_en,
  output logic                                   arr_rd_hl,
  output logic                                   rd_valid,
  output logic                                   busy,
  output logic                                   result_ready,
  output logic [31:0]                            perf_cycles
);

  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e   state;
  op_code_e op;
  logic     op_live;
  logic     accept;
  logic     cnt_zero;

  assign op      = op_code_e'(op_code);
  assign op_live = op_valid & is_matrix_op(op_code);
  assign stall   = op_live & (state != S_IDLE);
  assign accept  = op_live & (state == S_IDLE);
  assign busy    = (state != S_IDLE);

  matmul_step_counter #(.WIDTH(CNT_W)) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept & (op == OP_MATMUL)),
    .load_val (CNT_W'(STEPS - 1)),
    .dec      ((state == S_RUN) & ~cnt_zero),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      arr_wr_en    <= 1'b0;
      arr_wr_sel   <= WR_SEL_NONE;
      arr_row      <= '0;
      arr_step     <= 1'b0;
      arr_rd_en    <= 1'b0;
      arr_rd_hl    <= 1'b0;
      rd_valid     <= 1'b0;
      result_ready <= 1'b0;
    end else begin
      // Strobes are single-cycle; row/select fields only carry data alongside one.
      arr_wr_en  <= 1'b0;
      arr_wr_sel <= WR_SEL_NONE;
      arr_row    <= '0;
      arr_step   <= 1'b0;
      arr_rd_en  <= 1'b0;
      arr_rd_hl  <= 1'b0;
      rd_valid   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_WRITE_A, OP_WRITE_B, OP_WRITE_C: begin
                arr_wr_en    <= 1'b1;
                arr_wr_sel   <= op_code[1:0];
                arr_row      <= op_idx;
                // New operand data invalidates any previous product.
                result_ready <= 1'b0;
              end
              OP_SYS_STEP: arr_step <= 1'b1;
              OP_MATMUL: begin
                arr_step <= 1'b1;
                state    <= S_RUN;
              end
              OP_READ_C: begin
                arr_rd_en <= 1'b1;
                arr_row   <= op_idx;
                arr_rd_hl <= op_high_low;
                state     <= S_READ;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cnt_zero) begin
            state        <= S_IDLE;
            result_ready <= 1'b1;
          end else begin
            arr_step <= 1'b1;
          end
        end
        S_READ: begin
          rd_valid <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MATMUL_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if ((state == S_RUN) && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed literal checks plus randomized ops compared every
// cycle against a timeline model (ops schedule their effects at absolute
// future cycles; the sequencer is busy until a recorded free cycle).
module tb_matmul_seq;

  localparam int STEPS = 10;
  localparam int MAXC  = 256;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [1:0]  op_idx;
  logic        op_high_low;
  logic        stall;
  logic        arr_wr_en;
  logic [1:0]  arr_wr_sel;
  logic [1:0]  arr_row;
  logic        arr_step;
  logic        arr_rd_en;
  logic        arr_rd_hl;
  logic        rd_valid;
  logic        busy;
  logic        result_ready;
  logic [31:0] perf_cycles;

  matmul_seq dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_idx       (op_idx),
    .op_high_low  (op_high_low),
    .stall        (stall),
    .arr_wr_en    (arr_wr_en),
    .arr_wr_sel   (arr_wr_sel),
    .arr_row      (arr_row),
    .arr_step     (arr_step),
    .arr_rd_en    (arr_rd_en),
    .arr_rd_hl    (arr_rd_hl),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .result_ready (result_ready),
    .perf_cycles  (perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // ---------------- timeline model ----------------
  bit       s_wr   [MAXC];
  bit [1:0] s_sel  [MAXC];
  bit [1:0] s_row  [MAXC];
  bit       s_step [MAXC];
  bit       s_rd   [MAXC];
  bit       s_hl   [MAXC];
  bit       s_rdv  [MAXC];
  bit       s_rrset[MAXC];
  bit       s_rrclr[MAXC];
  bit       s_run  [MAXC];
  int       free_at  = 0;
  bit       rr       = 1'b0;
  int       perf_acc = 0;

  function automatic void clear_slot(input int k);
    s_wr[k] = 0; s_sel[k] = 0; s_row[k] = 0; s_step[k] = 0; s_rd[k] = 0;
    s_hl[k] = 0; s_rdv[k] = 0; s_rrset[k] = 0; s_rrclr[k] = 0; s_run[k] = 0;
  endfunction

  always @(negedge clk) begin
    int  k;
    bit  busy_e, live;
    logic [31:0] perf_e;
    k = cyc % MAXC;
    if (rst) begin
      for (int i = 0; i < MAXC; i++) clear_slot(i);
      free_at  = 0;
      rr       = 1'b0;
      perf_acc = 0;
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_wr_en", {31'd0, arr_wr_en}, 0);
      chk("rst_step", {31'd0, arr_step}, 0);
      chk("rst_rd_en", {31'd0, arr_rd_en}, 0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_result_ready", {31'd0, result_ready}, 0);
      chk("rst_perf", perf_cycles, 0);
    end else begin
      if (s_rrclr[k]) rr = 1'b0;
      if (s_rrset[k]) rr = 1'b1;
      busy_e = (cyc < free_at);
      live   = op_valid && (op_code != 3'b000) && (op_code != 3'b111);
      chk("stall", {31'd0, stall}, {31'd0, live && busy_e});
      chk("busy", {31'd0, busy}, {31'd0, busy_e});
      chk("wr_en", {31'd0, arr_wr_en}, {31'd0, s_wr[k]});
      if (s_wr[k]) begin
        chk("wr_sel", {30'd0, arr_wr_sel}, {30'd0, s_sel[k]});
        chk("wr_row", {30'd0, arr_row}, {30'd0, s_row[k]});
      end
      chk("step", {31'd0, arr_step}, {31'd0, s_step[k]});
      chk("rd_en", {31'd0, arr_rd_en}, {31'd0, s_rd[k]});
      if (s_rd[k]) begin
        chk("rd_row", {30'd0, arr_row}, {30'd0, s_row[k]});
        chk("rd_hl", {31'd0, arr_rd_hl}, {31'd0, s_hl[k]});
      end
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, s_rdv[k]});
      chk("result_ready", {31'd0, result_ready}, {31'd0, rr});
`ifdef MATMUL_SEQ_PERF_EN
      perf_e = perf_acc;
`else
      perf_e = 0;
`endif
      chk("perf", perf_cycles, perf_e);
      if (s_run[k]) perf_acc++;
      clear_slot(k);
      if (live && !busy_e) begin
        case (op_code)
          3'b001, 3'b010, 3'b011: begin
            s_wr[(cyc + 1) % MAXC]    = 1;
            s_sel[(cyc + 1) % MAXC]   = op_code[1:0];
            s_row[(cyc + 1) % MAXC]   = op_idx;
            s_rrclr[(cyc + 1) % MAXC] = 1;
          end
          3'b110: s_step[(cyc + 1) % MAXC] = 1;
          3'b100: begin
            for (int d = 1; d <= STEPS; d++) begin
              s_step[(cyc + d) % MAXC] = 1;
              s_run[(cyc + d) % MAXC]  = 1;
            end
            s_rrset[(cyc + STEPS + 1) % MAXC] = 1;
            free_at = cyc + STEPS + 1;
          end
          3'b101: begin
            s_rd[(cyc + 1) % MAXC]  = 1;
            s_row[(cyc + 1) % MAXC] = op_idx;
            s_hl[(cyc + 1) % MAXC]  = op_high_low;
            s_rdv[(cyc + 2) % MAXC] = 1;
            free_at = cyc + 2;
          end
          default: ;
        endcase
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit v, input logic [2:0] c, input logic [1:0] idx, input bit hl);
    op_valid    = v;
    op_code     = c;
    op_idx      = idx;
    op_high_low = hl;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    set_op(0, 3'b000, 2'd0, 0);
    repeat (3) @(negedge clk);
    chk("lit_reset_busy", {31'd0, busy}, 0);
    chk("lit_reset_rr", {31'd0, result_ready}, 0);

    // writeA row 2 on the first cycle out of reset
    next_cycle();
    rst = 1'b0;
    set_op(1, 3'b001, 2'd2, 0);
    @(negedge clk);
    chk("lit_wa_stall", {31'd0, stall}, 0);
    next_cycle();
    set_op(0, 3'b000, 2'd0, 0);
    @(negedge clk);
    chk("lit_wa_en", {31'd0, arr_wr_en}, 1);
    chk("lit_wa_sel", {30'd0, arr_wr_sel}, 32'd1);
    chk("lit_wa_row", {30'd0, arr_row}, 32'd2);
    next_cycle();
    @(negedge clk);
    chk("lit_wa_en_off", {31'd0, arr_wr_en}, 0);

    // matmul, then writeB held while RUN
    next_cycle();
    set_op(1, 3'b100, 2'd0, 0);
    @(negedge clk);
    next_cycle();
    set_op(1, 3'b010, 2'd1, 0);
    for (int i = 1; i <= STEPS; i++) begin
      @(negedge clk);
      chk("lit_mm_step", {31'd0, arr_step}, 1);
      chk("lit_mm_stall", {31'd0, stall}, 1);
      next_cycle();
    end
    @(negedge clk);
    chk("lit_mm_done_stall", {31'd0, stall}, 0);
    chk("lit_mm_done_rr", {31'd0, result_ready}, 1);
    chk("lit_mm_done_step", {31'd0, arr_step}, 0);
    next_cycle();
    set_op(0, 3'b000, 2'd0, 0);
    @(negedge clk);
    chk("lit_wb_en", {31'd0, arr_wr_en}, 1);
    chk("lit_wb_sel", {30'd0, arr_wr_sel}, 32'd2);
    chk("lit_wb_rr", {31'd0, result_ready}, 0);

    // readC row 3 high half, systolicstep held behind it
    next_cycle();
    set_op(1, 3'b101, 2'd3, 1);
    @(negedge clk);
    next_cycle();
    set_op(1, 3'b110, 2'd0, 0);
    @(negedge clk);
    chk("lit_rc_en", {31'd0, arr_rd_en}, 1);
    chk("lit_rc_row", {30'd0, arr_row}, 32'd3);
    chk("lit_rc_hl", {31'd0, arr_rd_hl}, 1);
    chk("lit_rc_stall", {31'd0, stall}, 1);
    next_cycle();
    @(negedge clk);
    chk("lit_rc_valid", {31'd0, rd_valid}, 1);
    chk("lit_rc_stall2", {31'd0, stall}, 0);
    next_cycle();
    set_op(0, 3'b000, 2'd0, 0);
    @(negedge clk);
    chk("lit_ss_step", {31'd0, arr_step}, 1);

    // null codes during RUN, then reset at RUN cycle 4
    next_cycle();
    set_op(1, 3'b100, 2'd0, 0);
    @(negedge clk);
    next_cycle();
    set_op(1, 3'b111, 2'd0, 0);
    @(negedge clk);
    chk("lit_op7_stall", {31'd0, stall}, 0);
    next_cycle();
    set_op(1, 3'b000, 2'd0, 0);
    @(negedge clk);
    chk("lit_op0_stall", {31'd0, stall}, 0);
    next_cycle();
    set_op(0, 3'b000, 2'd0, 0);
    @(negedge clk);
    next_cycle();
    chk("lit_run4_step", {31'd0, arr_step}, 1);
    rst = 1'b1;
    #1;
    chk("lit_arst_step", {31'd0, arr_step}, 0);
    chk("lit_arst_busy", {31'd0, busy}, 0);
    chk("lit_arst_perf", perf_cycles, 0);
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    set_op(1, 3'b100, 2'd0, 0);
    @(negedge clk);
    next_cycle();
    set_op(0, 3'b000, 2'd0, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arr_step) cnt++;
      next_cycle();
    end
    chk("lit_run_len", cnt, STEPS);
    set_op(1, 3'b100, 2'd0, 0);
    @(negedge clk);
    next_cycle();
    set_op(0, 3'b000, 2'd0, 0);
    repeat (14) begin
      @(negedge clk);
      next_cycle();
    end
    @(negedge clk);
    chk("lit_two_idle", {31'd0, busy}, 0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("lit_perf_two", perf_cycles, 32'd20);
`else
    chk("lit_perf_two", perf_cycles, 32'd0);
`endif

    // randomized ops with occasional reset pulses
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if (!(stall && op_valid))
        set_op($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    next_cycle();
    rst = 1'b0;
    set_op(0, 3'b000, 2'd0, 0);
    repeat (15) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter DIM, 4, systolic array edge length (rows/cols).
REQ-002 Parameter STEPS, 3*DIM-2 (10), systolic steps per full matmul.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 op_valid  in  1  decode presents a matrix op this cycle.
REQ-007 op_code  in  3  001 writeA, 010 writeB, 011 writeC, 100 matmul, 101 readC, 110 systolicstep; 000/111 = none.
REQ-008 op_idx  in  log2(DIM)  target row for write/read.
REQ-009 op_high_low  in  1  readC half select.
REQ-010 stall  out  1  op not accepted; decode holds op stable.
REQ-011 arr_wr_en  out  1  one-cycle array row write strobe.
REQ-012 arr_wr_sel  out  2  01 A, 10 B, 11 C.
REQ-013 arr_row  out  log2(DIM)  row for write/read.
REQ-014 arr_step  out  1  advance systolic array one step.
REQ-015 arr_rd_en  out  1  array row read strobe; arr_rd_hl  out  1  half select.
REQ-016 rd_valid  out  1  readC data valid toward vector writeback.
REQ-017 busy  out  1  state != IDLE.
REQ-018 result_ready  out  1  C holds a completed matmul result.
REQ-019 perf_cycles  out  32  RUN-cycle counter (see Configuration).

Function
REQ-020 States IDLE, RUN, READ; reset state IDLE.
REQ-021 Accept = op_valid & op_code in {001..110} & !stall; stall = op_valid & op_code in {001..110} & (state != IDLE), combinational.
REQ-022 Codes 000/111 never stall and have no effect.
REQ-023 Accepted writeA/B/C at cycle t: arr_wr_en=1, arr_wr_sel=op_code[1:0], arr_row=op_idx at t+1 for exactly one cycle; state stays IDLE; result_ready cleared at t+1.
REQ-024 Accepted systolicstep at t: arr_step=1 at t+1 for one cycle; state stays IDLE.
REQ-025 Accepted matmul at t: RUN from t+1; arr_step=1 every RUN cycle; exactly STEPS cycles; down-counter loaded STEPS-1, returns to IDLE after cycle where counter==0.
REQ-026 result_ready set in first IDLE cycle after RUN; held until writeA/B/C accepted or reset.
REQ-027 Accepted readC at t: arr_rd_en=1, arr_row=op_idx, arr_rd_hl=op_high_low at t+1; state READ at t+1; rd_valid=1 at t+2; IDLE at t+2.
REQ-028 readC with result_ready=0 still executes (returns current C contents).
REQ-029 Back-to-back ops in IDLE accepted every cycle (writes, systolicstep); op presented during RUN/READ stalls until first IDLE cycle, then accepted.
REQ-030 All strobe outputs registered; no output asserted in same cycle as acceptance.

Reset
REQ-031 rst asserted (any state, including mid-RUN/READ): state IDLE, counter 0, all outputs 0, result_ready 0, perf_cycles 0, asynchronously.
REQ-032 First op after deassertion accepted on first clk edge with rst low.

Configuration
REQ-033 Macro MATMUL_SEQ_PERF_EN defined: perf_cycles increments each RUN cycle, saturates at 32'hFFFF_FFFF, cleared only by reset.
REQ-034 Macro undefined: perf_cycles tied to 0, no counter flops.

Structure
REQ-035 Shared package matmul_pkg holds op_code enum (values per REQ-007), wr_sel encoding, DIM default, STEPS formula.
REQ-036 One sub-module matmul_step_counter: load/decrement/zero-flag down-counter of width clog2(STEPS).

Verification
REQ-037 writeA idx=2 at t -> arr_wr_en=1, sel=01, row=2 at t+1 only; stall=0 throughout.
REQ-038 matmul at t, writeB at t+1 held -> arr_step high t+1..t+10 (10 cycles), stall=1 t+1..t+10, writeB accepted t+11, arr_wr_en at t+12, result_ready=1 at t+11 then 0 at t+12.
REQ-039 readC idx=3 hl=1 at t, systolicstep at t+1 -> arr_rd_en/row=3/hl=1 at t+1, stall=1 at t+1, rd_valid at t+2, arr_step at t+3.
REQ-040 rst pulsed at RUN cycle 4 -> all outputs 0 immediately, busy=0, next matmul runs full 10 steps.
REQ-041 op_code 111 and 000 with op_valid=1 during RUN -> stall=0, no strobes.
REQ-042 With MATMUL_SEQ_PERF_EN: two matmuls -> perf_cycles=20; without it -> 0.
